// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory access controller.
// Takes one load/store at a time from EX/MEM and turns it into a word-aligned,
// handshaked request to a multi-cycle data memory. Loads are aligned and
// extended into load_data. The pipeline is held with mem_stall while the access
// is outstanding.
module mem_access_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        mem_stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        acc_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             is_load_q, uns_q, err_q;
  logic [1:0]       size_q, lane_q;
  logic             req_any, illegal, start, ack_hit, timeout_hit;
  logic [3:0]       be_nxt;
  logic [31:0]      wdata_nxt, ext_data;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;

  assign req_any     = mem_read | mem_write;
  assign start       = (state == IDLE) && req_any && !illegal;
  assign ack_hit     = (state == REQ) && dm_ack;
  assign timeout_hit = (state == REQ) && !dm_ack && (cnt == CNT_LAST);

  // Decode the incoming request: legality, byte enables and lane-replicated store data.
  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    illegal   = mem_read & mem_write;
    be_nxt    = 4'b1111;
    wdata_nxt = wdata;
    case (mem_size)
      2'b00: begin
        be_nxt    = 4'b0001 << addr[1:0];
        wdata_nxt = {4{wdata[7:0]}};
      end
      2'b01: begin
        if (addr[0]) illegal = 1'b1;
        be_nxt    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{wdata[15:0]}};
      end
      2'b10: begin
        if (addr[1:0] != 2'b00) illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  // Extract the addressed byte/halfword from the returned word and extend it.
  always_comb begin
    rd_byte  = dm_rdata[{lane_q, 3'b000} +: 8];
    rd_half  = dm_rdata[{lane_q[1], 4'b0000} +: 16];
    ext_data = dm_rdata;
    case (size_q)
      2'b00:   ext_data = {{24{~uns_q & rd_byte[7]}}, rd_byte};
      2'b01:   ext_data = {{16{~uns_q & rd_half[15]}}, rd_half};
      default: ext_data = dm_rdata;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: one access at a time, DONE always lasts a single cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = REQ;
      REQ:     if (ack_hit || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Combinational outputs: stall and the illegal-access error are visible in the
  // request cycle itself; both are held low while reset is asserted.
  always_comb begin
    mem_stall = 1'b0;
    acc_err   = 1'b0;
    case (state)
      IDLE: begin
        mem_stall = rst_n & req_any & ~illegal;
        acc_err   = rst_n & req_any & illegal;
      end
      REQ:     mem_stall = 1'b1;
      DONE:    acc_err   = err_q;
      default: ;
    endcase
  end

  // Timeout counter: counts REQ cycles without an ack, cleared everywhere else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        cnt <= '0;
    else if ((state == REQ) && !dm_ack && !timeout_hit) cnt <= cnt + 1'b1;
    else                                               cnt <= '0;
  end

  // Memory-side request registers and load controls, captured on a legal start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_req    <= 1'b0;
      dm_we     <= 1'b0;
      dm_addr   <= '0;
      dm_be     <= '0;
      dm_wdata  <= '0;
      is_load_q <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= '0;
      lane_q    <= '0;
    end else begin
      dm_req <= (state_nxt == REQ);
      if (start) begin
        dm_we     <= mem_write;
        dm_addr   <= {addr[31:2], 2'b00};
        dm_be     <= be_nxt;
        dm_wdata  <= wdata_nxt;
        is_load_q <= mem_read;
        uns_q     <= mem_unsigned;
        size_q    <= mem_size;
        lane_q    <= addr[1:0];
      end
    end
  end

  // Completion registers: load result, load_valid pulse and timeout error flag for DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_data  <= '0;
      load_valid <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      load_valid <= ack_hit & is_load_q;
      err_q      <= timeout_hit;
      if (ack_hit && is_load_q) load_data <= ext_data;
      else if (timeout_hit)     load_data <= '0;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and randomized checks of mem_access_ctrl against a
// behavioural model of the access rules (legality, byte enables, store
// replication, load extraction, cycle timing).
module tb_mem_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write, mem_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] addr, wdata;
  logic        dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata, load_data;
  logic [3:0]  dm_be;
  logic        mem_stall, load_valid, acc_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(TO), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .addr(addr), .wdata(wdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_stall(mem_stall), .load_data(load_data), .load_valid(load_valid),
    .acc_err(acc_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic bit ref_legal(input bit r, input bit w, input logic [1:0] sz,
                                   input logic [31:0] a);
    if (r && w) return 1'b0;
    if (sz == 2'b11) return 1'b0;
    return (int'(a[1:0]) % nbytes(sz)) == 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] a);
    int m;
    m = ((1 << nbytes(sz)) - 1) << int'(a[1:0]);
    return 4'(m);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] wd);
    case (nbytes(sz))
      1:       return 32'(wd[7:0]) * 32'h0101_0101;
      2:       return 32'(wd[15:0]) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit uns,
                                           input logic [31:0] a, input logic [31:0] rd);
    logic [63:0] v, mask;
    int nb;
    nb   = nbytes(sz);
    v    = 64'(rd) >> (8 * int'(a[1:0]));
    mask = (64'd1 << (8 * nb)) - 64'd1;
    v    = v & mask;
    if (!uns && v[8*nb-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      mem_read  = 1'b0;
      mem_write = 1'b0;
      addr      = $urandom;
      mem_size  = 2'($urandom);
      dm_ack    = 1'($urandom_range(0, 1));
      #1;
      check("idle stall", 32'(mem_stall), 32'd0);
      check("idle req", 32'(dm_req), 32'd0);
      check("idle err", 32'(acc_err), 32'd0);
      check("idle lvalid", 32'(load_valid), 32'd0);
    end
  endtask

  // One instruction: cycle 0 request, REQ cycles until ack/timeout, then DONE.
  // ack_at outside 1..TO means no ack at all.
  task automatic access(input string tag, input bit r, input bit w, input logic [1:0] sz,
                        input bit uns, input logic [31:0] a, input logic [31:0] wd,
                        input int ack_at, input logic [31:0] rd);
    bit legal, timed_out;
    legal     = ref_legal(r, w, sz, a);
    timed_out = (ack_at < 1) || (ack_at > TO);
    next_cycle();
    mem_read     = r;
    mem_write    = w;
    mem_size     = sz;
    mem_unsigned = uns;
    addr         = a;
    wdata        = wd;
    dm_ack       = 1'b0;
    dm_rdata     = $urandom;
    #1;
    check($sformatf("%s c0 stall", tag), 32'(mem_stall), 32'(legal));
    check($sformatf("%s c0 err", tag), 32'(acc_err), 32'(!legal));
    check($sformatf("%s c0 req", tag), 32'(dm_req), 32'd0);
    check($sformatf("%s c0 lvalid", tag), 32'(load_valid), 32'd0);
    if (!legal) return;
    for (int c = 1; c <= TO; c++) begin
      next_cycle();
      dm_ack   = (c == ack_at);
      dm_rdata = dm_ack ? rd : $urandom;
      #1;
      check($sformatf("%s c%0d req", tag, c), 32'(dm_req), 32'd1);
      check($sformatf("%s c%0d stall", tag, c), 32'(mem_stall), 32'd1);
      check($sformatf("%s c%0d err", tag, c), 32'(acc_err), 32'd0);
      check($sformatf("%s c%0d lvalid", tag, c), 32'(load_valid), 32'd0);
      check($sformatf("%s c%0d we", tag, c), 32'(dm_we), 32'(w));
      check($sformatf("%s c%0d addr", tag, c), dm_addr, {a[31:2], 2'b00});
      check($sformatf("%s c%0d be", tag, c), 32'(dm_be), 32'(ref_be(sz, a)));
      check($sformatf("%s c%0d wdata", tag, c), dm_wdata, ref_wdata(sz, wd));
      if (dm_ack) break;
    end
    // DONE: a stray ack here must be ignored
    next_cycle();
    dm_ack   = 1'($urandom_range(0, 1));
    dm_rdata = $urandom;
    #1;
    check($sformatf("%s done req", tag), 32'(dm_req), 32'd0);
    check($sformatf("%s done stall", tag), 32'(mem_stall), 32'd0);
    check($sformatf("%s done err", tag), 32'(acc_err), 32'(timed_out));
    check($sformatf("%s done lvalid", tag), 32'(load_valid), 32'(r && !timed_out));
    if (timed_out)
      check($sformatf("%s done ldata", tag), load_data, 32'd0);
    else if (r)
      check($sformatf("%s done ldata", tag), load_data, ref_load(sz, uns, a, rd));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit          rr, ww;
    logic [1:0]  sz;
    logic [31:0] a;
    int          sel, ack;

    rst_n        = 1'b0;
    mem_read     = 1'b1;
    mem_write    = 1'b0;
    mem_size     = 2'b10;
    mem_unsigned = 1'b0;
    addr         = 32'h0000_0100;
    wdata        = 32'h0;
    dm_ack       = 1'b0;
    dm_rdata     = 32'h0;
    #2;
    check("rst dm_req", 32'(dm_req), 32'd0);
    check("rst dm_we", 32'(dm_we), 32'd0);
    check("rst dm_addr", dm_addr, 32'd0);
    check("rst dm_be", 32'(dm_be), 32'd0);
    check("rst dm_wdata", dm_wdata, 32'd0);
    check("rst load_data", load_data, 32'd0);
    check("rst load_valid", 32'(load_valid), 32'd0);
    check("rst stall legal req", 32'(mem_stall), 32'd0);
    check("rst acc_err", 32'(acc_err), 32'd0);
    mem_write = 1'b1;
    #1;
    check("rst acc_err illegal req", 32'(acc_err), 32'd0);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // directed accesses
    access("lb", 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_1003, $urandom, 1, 32'h80AA_BBCC);
    check("lb load_data const", load_data, 32'hFFFF_FF80);
    check("lb load_valid const", 32'(load_valid), 32'd1);
    access("lhu", 1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_2002, $urandom, 3, 32'h9234_5678);
    check("lhu load_data const", load_data, 32'h0000_9234);
    access("sb", 1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_3001, 32'h0000_00A5, 2, $urandom);
    access("lw_mis", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_4002, $urandom, 1, $urandom);
    access("rw_both", 1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_4000, $urandom, 1, $urandom);
    access("sz11", 1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_4000, $urandom, 1, $urandom);
    idle(1);
    access("lw_to", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_4000, $urandom, 0, $urandom);
    access("lw_last", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_4004, $urandom, TO, 32'hDEAD_BEEF);
    access("lh_b2b", 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_4006, $urandom, 1, 32'h8001_7FFF);
    access("sw_to", 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_4008, 32'h1234_5678, 0, $urandom);

    // reset in cycle 2 of a pending read; a late ack must be ignored
    next_cycle();
    mem_read  = 1'b1;
    mem_write = 1'b0;
    mem_size  = 2'b10;
    addr      = 32'h0000_5000;
    dm_ack    = 1'b0;
    #1;
    check("rstreq c0 stall", 32'(mem_stall), 32'd1);
    next_cycle();
    #1;
    check("rstreq c1 req", 32'(dm_req), 32'd1);
    next_cycle();
    #1;
    check("rstreq c2 req before", 32'(dm_req), 32'd1);
    rst_n    = 1'b0;
    mem_read = 1'b0;
    #1;
    check("rstreq c2 req dropped", 32'(dm_req), 32'd0);
    check("rstreq c2 stall dropped", 32'(mem_stall), 32'd0);
    #2;
    rst_n = 1'b1;
    next_cycle();
    dm_ack   = 1'b1;
    dm_rdata = $urandom;
    #1;
    check("rstreq c3 req", 32'(dm_req), 32'd0);
    check("rstreq c3 stall", 32'(mem_stall), 32'd0);
    next_cycle();
    dm_ack = 1'b0;
    #1;
    check("rstreq c4 lvalid", 32'(load_valid), 32'd0);
    check("rstreq c4 err", 32'(acc_err), 32'd0);
    check("rstreq c4 req", 32'(dm_req), 32'd0);

    // randomized accesses
    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom_range(0, 9));
      rr  = (sel < 5) || (sel == 9);
      ww  = (sel >= 5);
      sz  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a   = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      ack = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TO));
      access($sformatf("rnd%0d", i), rr, ww, sz, 1'($urandom_range(0, 1)), a, $urandom,
             ack, $urandom);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

endmodule
